// File: rtl/n4_b2_minmax_tracker.sv
// Window-based running min/max tracker for 4-bit unsigned samples.
// A window opens on start, takes COUNT samples over a valid/ready
// handshake, then holds the result with done until the consumer acks.

// Unsigned 4-bit magnitude comparator built on a subtractor borrow.
module n4_b2_comparator (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       flag_gr_o,
    output logic       flag_eq_o,
    output logic       flag_lr_o
);

    logic [4:0] diff;

    // Extended subtraction: bit 4 is the borrow, set exactly when a < b.
    always_comb begin
        diff      = {1'b0, a_i} - {1'b0, b_i};
        flag_lr_o = diff[4];
        flag_eq_o = (diff[3:0] == 4'd0);
        flag_gr_o = ~diff[4] & (diff[3:0] != 4'd0);
    end

endmodule

module n4_b2_minmax_tracker #(
    parameter int COUNT = 8
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] x3_x0,
    output logic [3:0] max3_max0,
    output logic [3:0] min3_min0,
    output logic [3:0] n3_n0,
    output logic [3:0] ties3_ties0,
    output logic       done,
    input  logic       ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Value of n on the accept that completes the window.
    localparam logic [3:0] LAST_N = 4'(COUNT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] max_q, max_d;
    logic [3:0] min_q, min_d;
    logic [3:0] n_q, n_d;
    logic [3:0] ties_q, ties_d;

    logic accept;
    logic max_gr, max_eq;
    logic min_lr;

    // Sample against the stored maximum: raise it or count a tie.
    n4_b2_comparator u_cmp_max (
        .a_i       (x3_x0),
        .b_i       (max_q),
        .flag_gr_o (max_gr),
        .flag_eq_o (max_eq),
        .flag_lr_o ()
    );

    // Sample against the stored minimum: lower it.
    n4_b2_comparator u_cmp_min (
        .a_i       (x3_x0),
        .b_i       (min_q),
        .flag_gr_o (),
        .flag_eq_o (),
        .flag_lr_o (min_lr)
    );

    // Handshake outputs depend on state only, never on in_valid.
    always_comb begin
        in_ready = (state_q == S_RUN);
        done     = (state_q == S_DONE);
        accept   = in_valid & in_ready;
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        n_d     = n_q;
        ties_d  = ties_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    n_d     = 4'd0;
                    ties_d  = 4'd0;
                end
            end

            S_RUN: begin
                if (accept) begin
                    if (n_q == 4'd0) begin
                        max_d = x3_x0;
                        min_d = x3_x0;
                    end else begin
                        if (max_gr) max_d  = x3_x0;
                        if (min_lr) min_d  = x3_x0;
                        if (max_eq) ties_d = ties_q + 4'd1;
                    end
                    n_d = n_q + 4'd1;
                    if (n_q == LAST_N) state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (ack) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset overriding all inputs.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!reset_) begin
            state_q <= S_IDLE;
            max_q   <= 4'd0;
            min_q   <= 4'd0;
            n_q     <= 4'd0;
            ties_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            n_q     <= n_d;
            ties_q  <= ties_d;
        end
    end

    assign max3_max0   = max_q;
    assign min3_min0   = min_q;
    assign n3_n0       = n_q;
    assign ties3_ties0 = ties_q;

endmodule
